// File: rtl/r_channel.sv
// ============================================================================
// r_channel : AXI4-Lite slave read-data channel (decode, memory read, timeout)
// Revision  : 1.0
// ============================================================================
`default_nettype none

module r_channel #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int ADDR_LIMIT = 1024,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  ADDRREADY,
   input  logic [ADDR_WIDTH-1:0] RADDRIN,
   output logic                  MEMRDEN,
   output logic [ADDR_WIDTH-1:0] MEMRADDR,
   input  logic                  MEMRVALID,
   input  logic [DATA_WIDTH-1:0] MEMRDATA,
   input  logic                  MEMRERR,
   output logic                  RVALID,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic [1:0]            RRESP,
   input  logic                  RREADY,
   output logic                  DATADONE
);

   localparam int                    CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [ADDR_WIDTH-1:0] LIMIT    = ADDR_WIDTH'(ADDR_LIMIT);
   localparam logic [1:0]            OKAY     = 2'b00;
   localparam logic [1:0]            SLVERR   = 2'b10;
   localparam logic [1:0]            DECERR   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t                  state, state_n;
   logic [CNT_W-1:0]        cnt, cnt_n;
   logic                    memrden_n;
   logic [ADDR_WIDTH-1:0]   memraddr_n;
   logic                    rvalid_n;
   logic [DATA_WIDTH-1:0]   rdata_n;
   logic [1:0]              rresp_n;
   logic                    datadone_n;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         cnt      <= '0;
         MEMRDEN  <= 1'b0;
         MEMRADDR <= '0;
         RVALID   <= 1'b0;
         RDATA    <= '0;
         RRESP    <= OKAY;
         DATADONE <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         MEMRDEN  <= memrden_n;
         MEMRADDR <= memraddr_n;
         RVALID   <= rvalid_n;
         RDATA    <= rdata_n;
         RRESP    <= rresp_n;
         DATADONE <= datadone_n;
      end
   end

   // Next-state logic computes the next value of every registered output.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      memrden_n  = 1'b0;
      memraddr_n = MEMRADDR;
      rvalid_n   = RVALID;
      rdata_n    = RDATA;
      rresp_n    = RRESP;
      datadone_n = 1'b0;
      case (state)
         IDLE: begin
            if (ADDRREADY) begin
               if (RADDRIN < LIMIT) begin
                  memraddr_n = RADDRIN;
                  memrden_n  = 1'b1;
                  state_n    = READ;
               end else begin
                  rdata_n  = '0;
                  rresp_n  = DECERR;
                  rvalid_n = 1'b1;
                  state_n  = RESP;
               end
            end
         end
         READ: begin
            cnt_n   = '0;
            state_n = WAIT;
         end
         WAIT: begin
            if (MEMRVALID) begin
               rdata_n  = MEMRDATA;
               rresp_n  = MEMRERR ? SLVERR : OKAY;
               rvalid_n = 1'b1;
               state_n  = RESP;
            end else if (cnt == CNT_LAST) begin
               rdata_n  = '0;
               rresp_n  = SLVERR;
               rvalid_n = 1'b1;
               state_n  = RESP;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         RESP: begin
            if (RREADY) begin
               rvalid_n   = 1'b0;
               datadone_n = 1'b1;
               state_n    = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

`default_nettype wire
